// File: rtl/wb_pkg.sv
// Shared definitions for the write-back port arbiter.
// Default widths match the 32x32 register file; REG_ZERO is the hardwired-zero
// register whose writes are accepted and discarded.
package wb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    // One write-back request at default widths: destination register index and data.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] dest;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

    // Round-robin successor of an index in a ring of n requesters.
    function automatic int rr_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Rotate-and-pick: scans mask starting at ptr and returns the first set index,
// plus the next set index that is compatible with the first one.
// compat[i][j]=1 means requests i and j may share a cycle.
module rr_pick2
    import wb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [N-1:0]  compat [N],
    input  logic [PW-1:0] ptr,
    output logic          first_vld,
    output logic [PW-1:0] first_idx,
    output logic          second_vld,
    output logic [PW-1:0] second_idx
);

    logic [PW-1:0] scan_idx;

    // Walk the ring from ptr; first hit takes the primary slot, the next
    // compatible hit takes the secondary slot.
    always_comb begin
        first_vld  = 1'b0;
        first_idx  = '0;
        second_vld = 1'b0;
        second_idx = '0;
        scan_idx   = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = PW'((int'(ptr) + k) % N);
            if (mask[scan_idx]) begin
                if (!first_vld) begin
                    first_vld = 1'b1;
                    first_idx = scan_idx;
                end else if (!second_vld && compat[first_idx][scan_idx]) begin
                    second_vld = 1'b1;
                    second_idx = scan_idx;
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter feeding the register file's primary and secondary write
// ports. Up to two requests are granted per cycle in round-robin order, never
// two to the same destination; writes to r0 are accepted and dropped.
// Ports are registered: a request accepted at edge N drives its port during
// cycle N+1.
// Handshake: a transfer happens on an edge where ReqValid[i] && ReqReady[i];
// a requester holds ReqValid/ReqReg/ReqData stable until then, and ReqReady
// never depends on anything the requester derives from it.
// Optional build macro WB_CONFLICT_STATS_EN adds a 16-bit saturating
// ConflictCount of cycles where a request lost only to a same-register primary.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      WbHold,
    input  logic [NUM_REQ-1:0]        ReqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] ReqReg,
    input  logic [NUM_REQ*DATA_W-1:0] ReqData,
    output logic [NUM_REQ-1:0]        ReqReady,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         WriteRegister,
    output logic [DATA_W-1:0]         WriteData,
    output logic                      RegWrite2,
    output logic [ADDR_W-1:0]         WriteRegister2,
    output logic [DATA_W-1:0]         WriteData2
`ifdef WB_CONFLICT_STATS_EN
    ,
    output logic [15:0]               ConflictCount
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      rr_ptr;
    logic [ADDR_W-1:0]  req_reg  [NUM_REQ];
    logic [DATA_W-1:0]  req_data [NUM_REQ];
    logic [NUM_REQ-1:0] zero_req;
    logic [NUM_REQ-1:0] port_mask;
    logic [NUM_REQ-1:0] compat   [NUM_REQ];
    logic               scan_en;
    logic               first_vld;
    logic [PW-1:0]      first_idx;
    logic               second_vld;
    logic [PW-1:0]      second_idx;

    assign scan_en = !Reset && !WbHold;

    // Split the flat request buses into per-requester fields.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_reg[i]  = ReqReg[i*ADDR_W +: ADDR_W];
            req_data[i] = ReqData[i*DATA_W +: DATA_W];
        end
    end

    // Classify requests: r0 discards vs port candidates, plus pairwise compatibility.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            zero_req[i]  = scan_en && ReqValid[i] && (req_reg[i] == ADDR_W'(REG_ZERO));
            port_mask[i] = scan_en && ReqValid[i] && (req_reg[i] != ADDR_W'(REG_ZERO));
            for (int j = 0; j < NUM_REQ; j++) begin
                compat[i][j] = (req_reg[i] != req_reg[j]);
            end
        end
    end

    rr_pick2 #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .mask       (port_mask),
        .compat     (compat),
        .ptr        (rr_ptr),
        .first_vld  (first_vld),
        .first_idx  (first_idx),
        .second_vld (second_vld),
        .second_idx (second_idx)
    );

    // Accept r0 discards and the (at most two) port grants.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ReqReady[i] = zero_req[i]
                       || (first_vld  && (first_idx  == PW'(i)))
                       || (second_vld && (second_idx == PW'(i)));
        end
    end

    // Load the write ports from this cycle's grants and advance the pointer
    // past the last port grant; reset cancels any pending port write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWrite       <= 1'b0;
            WriteRegister  <= '0;
            WriteData      <= '0;
            RegWrite2      <= 1'b0;
            WriteRegister2 <= '0;
            WriteData2     <= '0;
            rr_ptr         <= '0;
        end else begin
            RegWrite  <= first_vld;
            RegWrite2 <= second_vld;
            if (first_vld) begin
                WriteRegister <= req_reg[first_idx];
                WriteData     <= req_data[first_idx];
            end
            if (second_vld) begin
                WriteRegister2 <= req_reg[second_idx];
                WriteData2     <= req_data[second_idx];
            end
            if (second_vld) begin
                rr_ptr <= PW'(rr_inc(int'(second_idx), NUM_REQ));
            end else if (first_vld) begin
                rr_ptr <= PW'(rr_inc(int'(first_idx), NUM_REQ));
            end
        end
    end

`ifdef WB_CONFLICT_STATS_EN
    logic conflict_hit;

    // A request counts as a conflict loss when it matches the primary's
    // register and a free secondary slot would otherwise have reached it.
    always_comb begin
        conflict_hit = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (port_mask[j] && first_vld && (PW'(j) != first_idx)
                && (req_reg[j] == req_reg[first_idx])) begin
                if (!second_vld
                    || (((j + NUM_REQ - int'(rr_ptr)) % NUM_REQ)
                        < ((int'(second_idx) + NUM_REQ - int'(rr_ptr)) % NUM_REQ))) begin
                    conflict_hit = 1'b1;
                end
            end
        end
    end

    // Saturating count of conflict-loss cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ConflictCount <= '0;
        end else if (conflict_hit && (ConflictCount != 16'hFFFF)) begin
            ConflictCount <= ConflictCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: reset checks, a table of per-cycle vectors with
// expected ReqReady and expected port contents, and a hand-written mid-flight
// reset sequence. Port expectations go into exp_q when a vector is driven and
// are popped after the following edge.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int EXP_W   = 2 + 2 * (1 + ADDR_W + DATA_W);
    localparam int NVEC    = 16;

    logic                      Clk;
    logic                      Reset;
    logic                      WbHold;
    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ*ADDR_W-1:0] ReqReg;
    logic [NUM_REQ*DATA_W-1:0] ReqData;
    logic [NUM_REQ-1:0]        ReqReady;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         WriteRegister;
    logic [DATA_W-1:0]         WriteData;
    logic                      RegWrite2;
    logic [ADDR_W-1:0]         WriteRegister2;
    logic [DATA_W-1:0]         WriteData2;
`ifdef WB_CONFLICT_STATS_EN
    logic [15:0]               ConflictCount;
`endif

    wb_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .WbHold         (WbHold),
        .ReqValid       (ReqValid),
        .ReqReg         (ReqReg),
        .ReqData        (ReqData),
        .ReqReady       (ReqReady),
        .RegWrite       (RegWrite),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .RegWrite2      (RegWrite2),
        .WriteRegister2 (WriteRegister2),
        .WriteData2     (WriteData2)
`ifdef WB_CONFLICT_STATS_EN
        ,
        .ConflictCount  (ConflictCount)
`endif
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- vectors ----------------
    typedef struct {
        logic        hold;
        logic [2:0]  valid;
        wb_req_t     req [NUM_REQ];
        logic [2:0]  exp_ready;
        logic        exp_we1;
        int          exp_src1;
        logic        exp_we2;
        int          exp_src2;
        logic [1:0]  exp_ptr;
    } vec_t;

    vec_t              vecs [NVEC];
    int                nvec;
    logic [DATA_W-1:0] dat [17];
    logic [EXP_W-1:0]  exp_q [$];

    int total;
    int bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic hold, input logic [2:0] valid,
                           input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [2:0] rdy, input logic we1, input int s1,
                           input logic we2, input int s2, input logic [1:0] ptr);
        vecs[nvec].hold        = hold;
        vecs[nvec].valid       = valid;
        vecs[nvec].req[0].dest = r0;
        vecs[nvec].req[0].data = d0;
        vecs[nvec].req[1].dest = r1;
        vecs[nvec].req[1].data = d1;
        vecs[nvec].req[2].dest = r2;
        vecs[nvec].req[2].data = d2;
        vecs[nvec].exp_ready   = rdy;
        vecs[nvec].exp_we1     = we1;
        vecs[nvec].exp_src1    = s1;
        vecs[nvec].exp_we2     = we2;
        vecs[nvec].exp_src2    = s2;
        vecs[nvec].exp_ptr     = ptr;
        nvec++;
    endtask

    // ---------------- driver ----------------
    task automatic drive_vec(input int i);
        WbHold   = vecs[i].hold;
        ReqValid = vecs[i].valid;
        ReqReg   = {vecs[i].req[2].dest, vecs[i].req[1].dest, vecs[i].req[0].dest};
        ReqData  = {vecs[i].req[2].data, vecs[i].req[1].data, vecs[i].req[0].data};
    endtask

    task automatic push_expected(input int i);
        logic [ADDR_W-1:0] r1, r2;
        logic [DATA_W-1:0] d1, d2;
        r1 = '0; d1 = '0; r2 = '0; d2 = '0;
        if (vecs[i].exp_we1) begin
            r1 = vecs[i].req[vecs[i].exp_src1].dest;
            d1 = vecs[i].req[vecs[i].exp_src1].data;
        end
        if (vecs[i].exp_we2) begin
            r2 = vecs[i].req[vecs[i].exp_src2].dest;
            d2 = vecs[i].req[vecs[i].exp_src2].data;
        end
        exp_q.push_back({vecs[i].exp_ptr, vecs[i].exp_we1, r1, d1, vecs[i].exp_we2, r2, d2});
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_ports();
        logic [1:0]        e_ptr;
        logic              e_we1, e_we2;
        logic [ADDR_W-1:0] e_reg1, e_reg2;
        logic [DATA_W-1:0] e_dat1, e_dat2;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_underflow: got 0 entries expected >0");
            return;
        end
        {e_ptr, e_we1, e_reg1, e_dat1, e_we2, e_reg2, e_dat2} = exp_q.pop_front();
        chk("reg_write", 64'(RegWrite), 64'(e_we1));
        if (e_we1) begin
            chk("write_register", 64'(WriteRegister), 64'(e_reg1));
            chk("write_data", 64'(WriteData), 64'(e_dat1));
        end
        chk("reg_write2", 64'(RegWrite2), 64'(e_we2));
        if (e_we2) begin
            chk("write_register2", 64'(WriteRegister2), 64'(e_reg2));
            chk("write_data2", 64'(WriteData2), 64'(e_dat2));
        end
        if (RegWrite && RegWrite2) begin
            chk("ports_distinct", 64'(WriteRegister == WriteRegister2), 64'(0));
        end
        chk("rr_ptr", 64'(dut.rr_ptr), 64'(e_ptr));
    endtask

    // ---------------- test ----------------
    initial begin
        total = 0;
        bad   = 0;
        nvec  = 0;
        for (int i = 0; i < 17; i++) dat[i] = $urandom_range(32'hFFFF_FFFF, 0);

        //      hold valid   r0  r1  r2  d0       d1       d2       rdy     we1 s1 we2 s2 ptr
        add_vec(0, 3'b111,   4,  5,  6,  dat[0],  dat[1],  dat[2],  3'b011, 1, 0, 1, 1, 2);
        add_vec(0, 3'b100,   4,  5,  6,  dat[0],  dat[1],  dat[2],  3'b100, 1, 2, 0, 0, 0);
        add_vec(0, 3'b011,   7,  7,  0,  dat[3],  dat[4],  0,       3'b001, 1, 0, 0, 0, 1);
        add_vec(0, 3'b010,   7,  7,  0,  dat[3],  dat[4],  0,       3'b010, 1, 1, 0, 0, 2);
        add_vec(0, 3'b111,   3,  8,  0,  dat[5],  dat[6],  dat[7],  3'b111, 1, 0, 1, 1, 2);
        add_vec(1, 3'b111,   9, 10, 11,  dat[8],  dat[9],  dat[10], 3'b000, 0, 0, 0, 0, 2);
        add_vec(1, 3'b111,   9, 10, 11,  dat[8],  dat[9],  dat[10], 3'b000, 0, 0, 0, 0, 2);
        add_vec(1, 3'b111,   9, 10, 11,  dat[8],  dat[9],  dat[10], 3'b000, 0, 0, 0, 0, 2);
        add_vec(0, 3'b111,   9, 10, 11,  dat[8],  dat[9],  dat[10], 3'b101, 1, 2, 1, 0, 1);
        add_vec(0, 3'b010,   9, 10, 11,  dat[8],  dat[9],  dat[10], 3'b010, 1, 1, 0, 0, 2);
        add_vec(0, 3'b101,  12, 10, 13,  dat[11], dat[9],  dat[12], 3'b101, 1, 2, 1, 0, 1);
        add_vec(0, 3'b001,  12, 10, 13,  dat[13], dat[9],  dat[12], 3'b001, 1, 0, 0, 0, 1);
        add_vec(0, 3'b111,  14, 15, 14,  dat[14], dat[15], dat[16], 3'b110, 1, 1, 1, 2, 0);
        add_vec(0, 3'b001,  14, 15, 14,  dat[14], dat[15], dat[16], 3'b001, 1, 0, 0, 0, 1);
        add_vec(0, 3'b111,   0,  0,  0,  dat[1],  dat[2],  dat[3],  3'b111, 0, 0, 0, 0, 1);
        add_vec(0, 3'b000,   0,  0,  0,  0,       0,       0,       3'b000, 0, 0, 0, 0, 1);

        // Reset held for two edges with every requester valid.
        Reset    = 1'b1;
        WbHold   = 1'b0;
        ReqValid = 3'b111;
        ReqReg   = {5'd6, 5'd5, 5'd4};
        ReqData  = {dat[2], dat[1], dat[0]};
        repeat (2) begin
            @(negedge Clk);
            chk("reset_ready", 64'(ReqReady), 64'(0));
            chk("reset_we1", 64'(RegWrite), 64'(0));
            chk("reset_we2", 64'(RegWrite2), 64'(0));
            chk("reset_reg1", 64'(WriteRegister), 64'(0));
            chk("reset_reg2", 64'(WriteRegister2), 64'(0));
            chk("reset_data1", 64'(WriteData), 64'(0));
            chk("reset_data2", 64'(WriteData2), 64'(0));
            chk("reset_ptr", 64'(dut.rr_ptr), 64'(0));
        end
        Reset = 1'b0;

        // Table: drive, check ready combinationally, check ports after the edge.
        for (int i = 0; i < nvec; i++) begin
            drive_vec(i);
            #1;
            chk($sformatf("ready_v%0d", i), 64'(ReqReady), 64'(vecs[i].exp_ready));
            push_expected(i);
            @(negedge Clk);
            check_ports();
        end
        chk("exp_q_empty", 64'(exp_q.size()), 64'(0));

`ifdef WB_CONFLICT_STATS_EN
        chk("conflict_count", 64'(ConflictCount), 64'(1));
`endif

        // Reset while two port writes are registered: both get cancelled.
        WbHold   = 1'b0;
        ReqValid = 3'b011;
        ReqReg   = {5'd0, 5'd21, 5'd20};
        ReqData  = {dat[2], dat[6], dat[5]};
        #1;
        chk("midrst_ready", 64'(ReqReady), 64'(3'b011));
        @(negedge Clk);
        chk("midrst_we1", 64'(RegWrite), 64'(1));
        chk("midrst_we2", 64'(RegWrite2), 64'(1));
        chk("midrst_reg1", 64'(WriteRegister), 64'(21));
        chk("midrst_reg2", 64'(WriteRegister2), 64'(20));
        chk("midrst_data1", 64'(WriteData), 64'(dat[6]));
        chk("midrst_data2", 64'(WriteData2), 64'(dat[5]));
        Reset    = 1'b1;
        ReqValid = 3'b111;
        ReqReg   = {5'd0, 5'd23, 5'd22};
        #1;
        chk("midrst_ready_in_reset", 64'(ReqReady), 64'(0));
        @(negedge Clk);
        chk("midrst_cancel_we1", 64'(RegWrite), 64'(0));
        chk("midrst_cancel_we2", 64'(RegWrite2), 64'(0));
        chk("midrst_ptr", 64'(dut.rr_ptr), 64'(0));
`ifdef WB_CONFLICT_STATS_EN
        chk("conflict_count_reset", 64'(ConflictCount), 64'(0));
`endif
        Reset    = 1'b0;
        ReqValid = 3'b000;
        @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
